cache_mem_arbiter: RTL

- Sits directly downstream of the I-cache and D-cache inside the mp3 top.
- Serialises their line-fill and write-back requests onto the single physical memory port (mem_read, mem_write, mem_addr, mem_wdata, mem_resp, mem_rdata), through the cacheline adaptor.
- Each granted transaction is latched and held stable until memory responds. The response is then returned to the owning cache as a one-cycle pulse.

---
 rtl/cache_mem_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Serialises I-cache line fills and D-cache fills/write-backs onto the single
//   physical memory port. A granted transaction is latched and held until the
//   adaptor responds; the result goes back to the owning cache as a one-cycle
//   resp pulse. All outputs are registered.
//
// Ports
//   clk, rst                      clock (rising edge), async active-low reset
//   icache_read/addr              I-cache fill request (held until icache_resp)
//   icache_rdata/resp             fill data and one-cycle completion to I-cache
//   dcache_read/write/addr/wdata  D-cache fill or write-back request
//   dcache_rdata/resp             fill data and one-cycle completion to D-cache
//   pmem_read/write/addr/wdata    latched transaction towards the adaptor
//   pmem_rdata/resp               adaptor return line and one-cycle completion
module cache_mem_arbiter #(
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter bit          D_PRIORITY = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  icache_read,
    input  logic [ADDR_WIDTH-1:0] icache_addr,
    output logic [LINE_WIDTH-1:0] icache_rdata,
    output logic                  icache_resp,

    input  logic                  dcache_read,
    input  logic                  dcache_write,
    input  logic [ADDR_WIDTH-1:0] dcache_addr,
    input  logic [LINE_WIDTH-1:0] dcache_wdata,
    output logic [LINE_WIDTH-1:0] dcache_rdata,
    output logic                  dcache_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_addr,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SERVE_I = 3'd1;
    localparam logic [2:0] SERVE_D = 3'd2;
    localparam logic [2:0] RESP_I  = 3'd3;
    localparam logic [2:0] RESP_D  = 3'd4;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic [2:0]            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  pmem_read_q, pmem_read_d;
    logic                  pmem_write_q, pmem_write_d;
    logic [ADDR_WIDTH-1:0] pmem_addr_q, pmem_addr_d;
    logic [LINE_WIDTH-1:0] pmem_wdata_q, pmem_wdata_d;
    logic [LINE_WIDTH-1:0] icache_rdata_q, icache_rdata_d;
    logic [LINE_WIDTH-1:0] dcache_rdata_q, dcache_rdata_d;
    logic                  icache_resp_q, icache_resp_d;
    logic                  dcache_resp_q, dcache_resp_d;

    logic d_req;
    logic take_d;

    assign d_req = dcache_read | dcache_write;

    // On a tie D wins outright under fixed priority; otherwise the source that
    // was not served last goes first.
    assign take_d = d_req & (~icache_read | D_PRIORITY | (last_grant_q == GRANT_I));

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_addr_d    = pmem_addr_q;
        pmem_wdata_d   = pmem_wdata_q;
        icache_rdata_d = icache_rdata_q;
        dcache_rdata_d = dcache_rdata_q;
        icache_resp_d  = 1'b0;
        dcache_resp_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (take_d) begin
                    state_d     = SERVE_D;
                    pmem_addr_d = dcache_addr;
                    // read+write together is a write-back
                    pmem_write_d = dcache_write;
                    pmem_read_d  = ~dcache_write;
                    if (dcache_write) begin
                        pmem_wdata_d = dcache_wdata;
                    end
                end else if (icache_read) begin
                    state_d     = SERVE_I;
                    pmem_addr_d = icache_addr;
                    pmem_read_d = 1'b1;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    state_d        = RESP_I;
                    pmem_read_d    = 1'b0;
                    pmem_write_d   = 1'b0;
                    icache_rdata_d = pmem_rdata;
                    icache_resp_d  = 1'b1;
                    last_grant_d   = GRANT_I;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    state_d = RESP_D;
                    // a write-back leaves the fill buffer untouched
                    if (pmem_read_q) begin
                        dcache_rdata_d = pmem_rdata;
                    end
                    pmem_read_d   = 1'b0;
                    pmem_write_d  = 1'b0;
                    dcache_resp_d = 1'b1;
                    last_grant_d  = GRANT_D;
                end
            end
            // One dead cycle lets the served cache drop its request before the
            // next arbitration, so a stale request is never granted again.
            RESP_I, RESP_D: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            last_grant_q   <= GRANT_I;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_addr_q    <= '0;
            pmem_wdata_q   <= '0;
            icache_rdata_q <= '0;
            dcache_rdata_q <= '0;
            icache_resp_q  <= 1'b0;
            dcache_resp_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_addr_q    <= pmem_addr_d;
            pmem_wdata_q   <= pmem_wdata_d;
            icache_rdata_q <= icache_rdata_d;
            dcache_rdata_q <= dcache_rdata_d;
            icache_resp_q  <= icache_resp_d;
            dcache_resp_q  <= dcache_resp_d;
        end
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_addr    = pmem_addr_q;
    assign pmem_wdata   = pmem_wdata_q;
    assign icache_rdata = icache_rdata_q;
    assign icache_resp  = icache_resp_q;
    assign dcache_rdata = dcache_rdata_q;
    assign dcache_resp  = dcache_resp_q;

endmodule
